// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and constants for the elevator scheduler
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    // Floor index width: max(1, clog2(n))
    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_scheduler_tick_sync.sv
// rtl/elevator_scheduler_tick_sync.sv - div_clk synchronizer and rising-edge tick
module tick_sync (
    input  logic clkin,
    input  logic rst_n,
    input  logic div_clk,
    output logic tick
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic dly_q, dly_d;

    // Two-flop synchronizer followed by one delay stage for edge detection
    always_comb begin
        s1_d  = div_clk;
        s2_d  = s1_q;
        dly_d = s2_q;
    end

    // Chain registers, cleared asynchronously
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            dly_q <= dly_d;
        end
    end

    assign tick = s2_q & ~dly_q;

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - LOOK-policy elevator car controller
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS     = 4,
    parameter int MOVE_TICKS = 3,
    parameter int DOOR_TICKS = 5
) (
    input  logic                          clkin,
    input  logic                          rst_n,
    input  logic                          div_clk,
    input  logic [FLOORS-1:0]             req,
    output logic [floor_w(FLOORS)-1:0]    floor,
    output logic                          dir_up,
    output logic                          moving,
    output logic                          door_open,
    output logic [FLOORS-1:0]             pending
);

    localparam int FLOOR_W = floor_w(FLOORS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   MOVE_CNT  = CNT_W'(MOVE_TICKS);
    localparam logic [CNT_W-1:0]   DOOR_CNT  = CNT_W'(DOOR_TICKS);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 dir_up_q, dir_up_d;
    logic [FLOORS-1:0]    pending_q, pending_d;
    logic [FLOORS-1:0]    clr;
    logic [FLOOR_W-1:0]   next_floor;
    logic                 above, below;
    logic                 tick;

    tick_sync u_tick_sync (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .div_clk (div_clk),
        .tick    (tick)
    );

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i > int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i < int'(f)) r = r | p[i];
        return r;
    endfunction

    // Next-state: LOOK scheduling, travel/dwell counting and request latching
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        clr        = '0;
        next_floor = floor_q;
        above      = any_above(pending_q, floor_q);
        below      = any_below(pending_q, floor_q);

        case (state_q)
            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d      = DOOR;
                    clr[floor_q] = 1'b1;
                    cnt_d        = DOOR_CNT;
                end else if ((dir_up_q && above) || (!dir_up_q && !below && above)) begin
                    dir_up_d = 1'b1;
                    state_d  = MOVE;
                    cnt_d    = MOVE_CNT;
                end else if (below) begin
                    dir_up_d = 1'b0;
                    state_d  = MOVE;
                    cnt_d    = MOVE_CNT;
                end
            end
            MOVE: begin
                if (tick) begin
                    if (cnt_q > CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (dir_up_q ? (floor_q == TOP_FLOOR) : (floor_q == '0)) begin
                        // Would step off the shaft: hold position and re-decide
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        next_floor = dir_up_q ? (floor_q + FLOOR_ONE) : (floor_q - FLOOR_ONE);
                        floor_d    = next_floor;
                        if (pending_q[next_floor]) begin
                            state_d         = DOOR;
                            clr[next_floor] = 1'b1;
                            cnt_d           = DOOR_CNT;
                        end else if (dir_up_q ? any_above(pending_q, next_floor)
                                              : any_below(pending_q, next_floor)) begin
                            cnt_d = MOVE_CNT;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            DOOR: begin
                // Presses at the open floor are absorbed and extend the dwell
                clr[floor_q] = 1'b1;
                if (req[floor_q]) begin
                    cnt_d = DOOR_CNT;
                end else if (tick) begin
                    if (cnt_q > CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        pending_d = (pending_q | req) & ~clr;
    end

    // State, counter, position and request registers
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
        end
    end

    assign floor     = floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = (state_q == MOVE);
    assign door_open = (state_q == DOOR);
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - directed self-checking bench for elevator_scheduler
module tb_elevator_scheduler;

    logic       clkin;
    logic       rst_n;
    logic       div_clk;
    logic [3:0] req;
    logic [1:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [3:0] pending;

    int n_checks;
    int n_fail;
    int door_opens;
    logic door_prev;

    elevator_scheduler #(
        .FLOORS     (4),
        .MOVE_TICKS (3),
        .DOOR_TICKS (5)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .div_clk   (div_clk),
        .req       (req),
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    always @(posedge clkin) begin
        door_prev <= door_open;
        if (door_open && !door_prev) door_opens <= door_opens + 1;
    end

    typedef struct {
        logic [3:0] req;
        int         cyc;
        int         ticks;
        logic [1:0] floor;
        logic       dir;
        logic       mov;
        logic       door;
        logic [3:0] pend;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [1:0] ef, input logic ed,
                         input logic em, input logic eo, input logic [3:0] ep);
        logic [8:0] got, exp;
        got = {floor, dir_up, moving, door_open, pending};
        exp = {ef, ed, em, eo, ep};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got floor=%0d dir_up=%b moving=%b door_open=%b pending=%b, expected floor=%0d dir_up=%b moving=%b door_open=%b pending=%b",
                     name, floor, dir_up, moving, door_open, pending, ef, ed, em, eo, ep);
        end
    endtask

    // One div_clk period: the tick is consumed three posedges after the rise
    task automatic tick_once();
        div_clk = 1'b1;
        repeat (4) @(negedge clkin);
        div_clk = 1'b0;
        repeat (4) @(negedge clkin);
    endtask

    task automatic pulse_req(input logic [3:0] r);
        req = r;
        @(negedge clkin);
        req = '0;
    endtask

    initial begin
        int opens_before;
        n_checks   = 0;
        n_fail     = 0;
        door_opens = 0;
        door_prev  = 1'b0;
        rst_n      = 1'b0;
        div_clk    = 1'b0;
        req        = '0;

        // Reset then idle
        repeat (3) @(negedge clkin);
        check("reset_values", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_once();
            check($sformatf("idle_tick%0d", i), 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        end

        // Single trip, reverse trip and LOOK ordering
        vecs[0]  = '{4'b1000, 0, 0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b1000};
        vecs[1]  = '{4'b0000, 1, 0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000};
        vecs[2]  = '{4'b0000, 0, 3, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000};
        vecs[3]  = '{4'b0000, 0, 6, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000};
        vecs[4]  = '{4'b0000, 0, 4, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000};
        vecs[5]  = '{4'b0000, 0, 1, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[6]  = '{4'b0010, 1, 0, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0010};
        vecs[7]  = '{4'b0000, 0, 6, 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[8]  = '{4'b0000, 0, 5, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[9]  = '{4'b1000, 1, 0, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000};
        vecs[10] = '{4'b1001, 0, 0, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1001};
        vecs[11] = '{4'b0000, 0, 6, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0001};
        vecs[12] = '{4'b0000, 0, 5, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[13] = '{4'b0000, 0, 9, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[14] = '{4'b0000, 0, 5, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000};

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].req != 4'b0000) pulse_req(vecs[i].req);
            repeat (vecs[i].cyc) @(negedge clkin);
            for (int t = 0; t < vecs[i].ticks; t++) tick_once();
            check($sformatf("vec%0d", i), vecs[i].floor, vecs[i].dir, vecs[i].mov,
                  vecs[i].door, vecs[i].pend);
        end

        // Current-floor request, then a reload two ticks into the dwell
        pulse_req(4'b0001);
        check("curfloor_pending", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
        @(negedge clkin);
        check("curfloor_door", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
        repeat (2) tick_once();
        pulse_req(4'b0001);
        check("curfloor_reload", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
        repeat (4) tick_once();
        check("curfloor_still_open", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
        tick_once();
        check("curfloor_closed", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Arrival collision: req[2] on the stepping edge with pending[2] set
        pulse_req(4'b0100);
        @(negedge clkin);
        check("collide_start", 2'd0, 1'b1, 1'b1, 1'b0, 4'b0100);
        opens_before = door_opens;
        repeat (5) tick_once();
        div_clk = 1'b1;
        repeat (2) @(negedge clkin);
        req = 4'b0100;
        @(negedge clkin);
        req = 4'b0000;
        check("collide_arrive", 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000);
        repeat (2) @(negedge clkin);
        div_clk = 1'b0;
        repeat (4) @(negedge clkin);
        repeat (5) tick_once();
        repeat (3) @(negedge clkin);
        check("collide_done", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
        n_checks++;
        if (door_opens - opens_before != 1) begin
            n_fail++;
            $display("FAIL collide_door_count: got %0d door openings, expected 1", door_opens - opens_before);
        end

        // Reset mid-MOVE at cnt = 1 with pending = 0110
        pulse_req(4'b0010);
        @(negedge clkin);
        pulse_req(4'b0100);
        repeat (2) tick_once();
        check("pre_reset_move", 2'd2, 1'b0, 1'b1, 1'b0, 4'b0110);
        rst_n = 1'b0;
        #1;
        check("async_reset", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        @(negedge clkin);
        rst_n = 1'b1;
        repeat (3) tick_once();
        check("post_reset_idle", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
